// File: rtl/siggen_sequencer.sv
// Segment-table sequencer driving one DAC channel of the waveform generator.
// Optional SIGGEN_SEQ_ZEROCROSS_EN: ramp to zero before changing type or increment.
module siggen_sequencer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AMP_WIDTH = 16,
    parameter int unsigned INC_WIDTH = 16,
    parameter int unsigned LEN_WIDTH = 32,
    parameter int unsigned RAMP_STEP = 64
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 cfg_wr_en,
    input  logic [ADDR_W-1:0]    cfg_wr_addr,
    input  logic [3:0]           cfg_wr_type,
    input  logic [AMP_WIDTH-1:0] cfg_wr_amp,
    input  logic [INC_WIDTH-1:0] cfg_wr_inc,
    input  logic [LEN_WIDTH-1:0] cfg_wr_len,
    input  logic [ADDR_W:0]      cfg_num_seg,
    input  logic                 loop_en,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 period_tick,
    output logic [3:0]           sig_type,
    output logic [AMP_WIDTH-1:0] sig_amp,
    output logic [INC_WIDTH-1:0] sig_phase_inc,
    output logic                 sig_phase_rst,
    output logic [ADDR_W-1:0]    seg_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SLEW,
        S_RUN,
        S_SLEW_DOWN,
        S_DONE,
        S_ZERO
    } state_t;

    localparam logic [AMP_WIDTH-1:0] STEP    = AMP_WIDTH'(RAMP_STEP);
    localparam logic [ADDR_W:0]      NUM_MAX = (ADDR_W+1)'(DEPTH);

    logic [3:0]           tbl_typ_q [DEPTH];
    logic [3:0]           tbl_typ_d [DEPTH];
    logic [AMP_WIDTH-1:0] tbl_amp_q [DEPTH];
    logic [AMP_WIDTH-1:0] tbl_amp_d [DEPTH];
    logic [INC_WIDTH-1:0] tbl_inc_q [DEPTH];
    logic [INC_WIDTH-1:0] tbl_inc_d [DEPTH];
    logic [LEN_WIDTH-1:0] tbl_len_q [DEPTH];
    logic [LEN_WIDTH-1:0] tbl_len_d [DEPTH];

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    seg_idx_q, seg_idx_d;
    logic [AMP_WIDTH-1:0] amp_q, amp_d;
    logic [AMP_WIDTH-1:0] tgt_q, tgt_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           typ_q, typ_d;
    logic [INC_WIDTH-1:0] inc_q, inc_d;
    logic                 prst_q, prst_d;
    logic [3:0]           ent_typ_q, ent_typ_d;
    logic [INC_WIDTH-1:0] ent_inc_q, ent_inc_d;
    logic                 ld_q, ld_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [AMP_WIDTH-1:0] slew_tgt, slew_amp;
    logic [ADDR_W:0]      nxt_sum;
    logic                 more;
    logic [ADDR_W-1:0]    nxt_idx;
    logic [LEN_WIDTH-1:0] cur_len, len_eff;

    always_comb begin
        tbl_typ_d = tbl_typ_q;
        tbl_amp_d = tbl_amp_q;
        tbl_inc_d = tbl_inc_q;
        tbl_len_d = tbl_len_q;
        if (cfg_wr_en) begin
            tbl_typ_d[cfg_wr_addr] = cfg_wr_type;
            tbl_amp_d[cfg_wr_addr] = cfg_wr_amp;
            tbl_inc_d[cfg_wr_addr] = cfg_wr_inc;
            tbl_len_d[cfg_wr_addr] = cfg_wr_len;
        end
    end

    // Step toward the target, landing exactly on it.
    always_comb begin
        slew_tgt = tgt_q;
        if (state_q == S_SLEW_DOWN || state_q == S_ZERO) begin
            slew_tgt = '0;
        end
        slew_amp = slew_tgt;
        if (amp_q < slew_tgt) begin
            if (slew_tgt - amp_q > STEP) begin
                slew_amp = amp_q + STEP;
            end
        end else if (amp_q - slew_tgt > STEP) begin
            slew_amp = amp_q - STEP;
        end
    end

    assign nxt_sum = {1'b0, seg_idx_q} + (ADDR_W+1)'(1);
    assign more    = nxt_sum < cfg_num_seg;
    assign nxt_idx = more ? nxt_sum[ADDR_W-1:0] : '0;
    assign cur_len = tbl_len_q[seg_idx_q];
    assign len_eff = (cur_len == '0) ? LEN_WIDTH'(1) : cur_len;

`ifdef SIGGEN_SEQ_ZEROCROSS_EN
    logic nxt_differs;
    assign nxt_differs = (tbl_typ_q[nxt_idx] != typ_q) ||
                         (tbl_inc_q[nxt_idx] != inc_q);
`endif

    always_comb begin
        state_d   = state_q;
        seg_idx_d = seg_idx_q;
        amp_d     = amp_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        typ_d     = typ_q;
        inc_d     = inc_q;
        prst_d    = 1'b0;
        ent_typ_d = ent_typ_q;
        ent_inc_d = ent_inc_q;
        ld_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // Entry fields fetched in LOAD reach the generator one cycle later.
        if (ld_q) begin
            typ_d  = ent_typ_q;
            inc_d  = ent_inc_q;
            prst_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (cfg_num_seg == '0 || cfg_num_seg > NUM_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        seg_idx_d = '0;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d = S_SLEW_DOWN;
                end else begin
                    ent_typ_d = tbl_typ_q[seg_idx_q];
                    ent_inc_d = tbl_inc_q[seg_idx_q];
                    tgt_d     = tbl_amp_q[seg_idx_q];
                    cnt_d     = len_eff;
                    ld_d      = 1'b1;
                    state_d   = S_SLEW;
                end
            end
            S_SLEW: begin
                amp_d = slew_amp;
                // Counter parks at 1 so the segment always ends in RUN.
                if (period_tick && cnt_q > LEN_WIDTH'(1)) begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                end
                if (stop) begin
                    state_d = S_SLEW_DOWN;
                end else if (slew_amp == tgt_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_SLEW_DOWN;
                end else if (period_tick) begin
                    if (cnt_q > LEN_WIDTH'(1)) begin
                        cnt_d = cnt_q - LEN_WIDTH'(1);
                    end else if (more || loop_en) begin
                        seg_idx_d = nxt_idx;
`ifdef SIGGEN_SEQ_ZEROCROSS_EN
                        state_d = nxt_differs ? S_ZERO : S_LOAD;
`else
                        state_d = S_LOAD;
`endif
                    end else begin
                        state_d = S_SLEW_DOWN;
                    end
                end
            end
            S_SLEW_DOWN: begin
                amp_d = slew_amp;
                if (slew_amp == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                typ_d   = '0;
                inc_d   = '0;
                state_d = S_IDLE;
            end
            S_ZERO: begin
                amp_d = slew_amp;
                if (stop) begin
                    state_d = S_SLEW_DOWN;
                end else if (slew_amp == '0) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk) begin
        tbl_typ_q <= tbl_typ_d;
        tbl_amp_q <= tbl_amp_d;
        tbl_inc_q <= tbl_inc_d;
        tbl_len_q <= tbl_len_d;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            seg_idx_q <= '0;
            amp_q     <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            typ_q     <= '0;
            inc_q     <= '0;
            prst_q    <= 1'b0;
            ent_typ_q <= '0;
            ent_inc_q <= '0;
            ld_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_idx_q <= seg_idx_d;
            amp_q     <= amp_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            typ_q     <= typ_d;
            inc_q     <= inc_d;
            prst_q    <= prst_d;
            ent_typ_q <= ent_typ_d;
            ent_inc_q <= ent_inc_d;
            ld_q      <= ld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sig_type      = typ_q;
    assign sig_amp       = amp_q;
    assign sig_phase_inc = inc_q;
    assign sig_phase_rst = prst_q;
    assign seg_idx       = seg_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_siggen_sequencer.sv
// Scoreboard bench for siggen_sequencer: expected traces queued at stimulus time.
module tb_siggen_sequencer;

    localparam int DEPTH = 8;
    localparam int ADDR_W = 3;
    localparam int AMP_WIDTH = 16;
    localparam int INC_WIDTH = 16;
    localparam int LEN_WIDTH = 32;

    logic                 clk;
    logic                 areset;
    logic                 cfg_wr_en;
    logic [ADDR_W-1:0]    cfg_wr_addr;
    logic [3:0]           cfg_wr_type;
    logic [AMP_WIDTH-1:0] cfg_wr_amp;
    logic [INC_WIDTH-1:0] cfg_wr_inc;
    logic [LEN_WIDTH-1:0] cfg_wr_len;
    logic [ADDR_W:0]      cfg_num_seg;
    logic                 loop_en;
    logic                 start;
    logic                 stop;
    logic                 period_tick;
    logic [3:0]           sig_type;
    logic [AMP_WIDTH-1:0] sig_amp;
    logic [INC_WIDTH-1:0] sig_phase_inc;
    logic                 sig_phase_rst;
    logic [ADDR_W-1:0]    seg_idx;
    logic                 busy;
    logic                 done;
    logic                 err;

    siggen_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AMP_WIDTH(AMP_WIDTH),
        .INC_WIDTH(INC_WIDTH), .LEN_WIDTH(LEN_WIDTH), .RAMP_STEP(64)
    ) dut (
        .clk(clk), .areset(areset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_type(cfg_wr_type), .cfg_wr_amp(cfg_wr_amp),
        .cfg_wr_inc(cfg_wr_inc), .cfg_wr_len(cfg_wr_len),
        .cfg_num_seg(cfg_num_seg), .loop_en(loop_en),
        .start(start), .stop(stop), .period_tick(period_tick),
        .sig_type(sig_type), .sig_amp(sig_amp),
        .sig_phase_inc(sig_phase_inc), .sig_phase_rst(sig_phase_rst),
        .seg_idx(seg_idx), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [AMP_WIDTH-1:0] amp;
        logic [3:0]           typ;
        logic                 rst;
        logic                 busy;
        logic                 done;
    } exp_t;

    exp_t sb[$];
    int   seg_q[$];
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_entry(input int a, input int t, input int amp,
                            input int inc, input int len);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = ADDR_W'(a);
        cfg_wr_type = 4'(t);
        cfg_wr_amp  = AMP_WIDTH'(amp);
        cfg_wr_inc  = INC_WIDTH'(inc);
        cfg_wr_len  = LEN_WIDTH'(len);
        step();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic push_exp(input int amp, input int typ, input bit rst,
                            input bit bsy, input bit dn);
        exp_t e;
        e.amp  = AMP_WIDTH'(amp);
        e.typ  = 4'(typ);
        e.rst  = rst;
        e.busy = bsy;
        e.done = dn;
        sb.push_back(e);
    endtask

    // Expected trace from the edge after a ramp-down begins at full scale.
    task automatic push_ramp_down(input int typ);
        int a;
        for (int j = 1; j <= 130; j++) begin
            a = 8191 - 64 * j;
            if (a < 0 || j > 128) a = 0;
            push_exp(a, (j <= 128) ? typ : 0, 1'b0, j <= 128, j == 129);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
        n_checks++;
        if (sig_amp !== '0 || sig_type !== '0 || sig_phase_inc !== '0) begin
            n_errors++;
            $display("FAIL reset_sig: amp=%0d type=%0d inc=%0d want 0/0/0",
                     sig_amp, sig_type, sig_phase_inc);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: busy=%b done=%b err=%b want 0/0/0",
                     busy, done, err);
        end
        n_checks++;
        if (seg_idx !== '0 || sig_phase_rst !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idx: seg_idx=%0d rst=%b want 0/0",
                     seg_idx, sig_phase_rst);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   c;
        int   a;
        wr_entry(0, 1, 8191, 10, 3);
        cfg_num_seg = 4'd1;
        loop_en = 1'b0;
        for (int i = 1; i <= 135; i++) begin
            a = (i >= 3) ? 64 * (i - 2) : 0;
            if (a > 8191) a = 8191;
            push_exp(a, (i >= 3) ? 1 : 0, i == 3, 1'b1, 1'b0);
        end
        start = 1'b1;
        c = 0;
        while (sb.size() > 0) begin
            step();
            start = 1'b0;
            c++;
            e = sb.pop_front();
            n_checks++;
            if (sig_amp !== e.amp || sig_type !== e.typ ||
                sig_phase_rst !== e.rst || busy !== e.busy ||
                done !== e.done) begin
                n_errors++;
                $display("FAIL single_up cyc %0d: amp=%0d type=%0d rst=%b busy=%b done=%b want amp=%0d type=%0d rst=%b busy=%b done=%b",
                         c, sig_amp, sig_type, sig_phase_rst, busy, done,
                         e.amp, e.typ, e.rst, e.busy, e.done);
            end
        end
        n_checks++;
        if (sig_phase_inc !== 16'd10) begin
            n_errors++;
            $display("FAIL single_inc: inc=%0d want 10", sig_phase_inc);
        end
        for (int t = 1; t <= 3; t++) begin
            period_tick = 1'b1;
            step();
            period_tick = 1'b0;
            if (t < 3) begin
                step();
                step();
            end
        end
        push_ramp_down(1);
        c = 0;
        while (sb.size() > 0) begin
            step();
            c++;
            e = sb.pop_front();
            n_checks++;
            if (sig_amp !== e.amp || sig_type !== e.typ ||
                sig_phase_rst !== e.rst || busy !== e.busy ||
                done !== e.done) begin
                n_errors++;
                $display("FAIL single_down cyc %0d: amp=%0d type=%0d rst=%b busy=%b done=%b want amp=%0d type=%0d rst=%b busy=%b done=%b",
                         c, sig_amp, sig_type, sig_phase_rst, busy, done,
                         e.amp, e.typ, e.rst, e.busy, e.done);
            end
        end
    endtask

    task automatic test_loop();
        int  max_amp;
        int  min_after;
        int  done_cnt;
        int  exp_idx;
        bit  reached;
        bit  ok;
        wr_entry(0, 2, 4096, 20, 2);
        wr_entry(1, 2, 1000, 20, 2);
        cfg_num_seg = 4'd2;
        loop_en = 1'b1;
        seg_q = {0, 1, 0, 1};
        max_amp = 0;
        min_after = 65535;
        done_cnt = 0;
        reached = 1'b0;
        ok = 1'b0;
        start = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            period_tick = (cyc % 16 == 15);
            step();
            start = 1'b0;
            if (int'(sig_amp) > max_amp) max_amp = int'(sig_amp);
            if (sig_amp == 16'd4096) reached = 1'b1;
            if (reached && int'(sig_amp) < min_after) min_after = int'(sig_amp);
            if (done) done_cnt++;
            if (sig_phase_rst) begin
                exp_idx = seg_q.pop_front();
                n_checks++;
                if (seg_idx !== ADDR_W'(exp_idx)) begin
                    n_errors++;
                    $display("FAIL loop_seq: seg_idx=%0d want %0d",
                             seg_idx, exp_idx);
                end
                if (seg_q.size() == 0) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        period_tick = 1'b0;
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL loop_budget: %0d loads missing", seg_q.size());
        end
        n_checks++;
        if (max_amp != 4096) begin
            n_errors++;
            $display("FAIL loop_max: max amp=%0d want 4096", max_amp);
        end
        n_checks++;
        if (min_after != 1000) begin
            n_errors++;
            $display("FAIL loop_min: min amp=%0d want 1000", min_after);
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_errors++;
            $display("FAIL loop_nodone: done pulses=%0d want 0", done_cnt);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (done) done_cnt++;
            if (!busy) break;
        end
        n_checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL loop_stop: done pulses=%0d busy=%b want 1/0",
                     done_cnt, busy);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_stop();
        exp_t e;
        int   c;
        bit   hit;
        wr_entry(0, 3, 8191, 7, 100);
        cfg_num_seg = 4'd1;
        start = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            start = 1'b0;
            if (sig_amp == 16'd8191) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL stop_ramp: amp=%0d want 8191", sig_amp);
        end
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        push_ramp_down(3);
        c = 0;
        while (sb.size() > 0) begin
            step();
            c++;
            e = sb.pop_front();
            n_checks++;
            if (sig_amp !== e.amp || sig_type !== e.typ ||
                sig_phase_rst !== e.rst || busy !== e.busy ||
                done !== e.done) begin
                n_errors++;
                $display("FAIL stop_down cyc %0d: amp=%0d type=%0d rst=%b busy=%b done=%b want amp=%0d type=%0d rst=%b busy=%b done=%b",
                         c, sig_amp, sig_type, sig_phase_rst, busy, done,
                         e.amp, e.typ, e.rst, e.busy, e.done);
            end
        end
    endtask

    task automatic test_errors();
        logic [AMP_WIDTH-1:0] a0;
        int bad [2];
        bad[0] = 0;
        bad[1] = 9;
        for (int k = 0; k < 2; k++) begin
            cfg_num_seg = 4'(bad[k]);
            start = 1'b1;
            step();
            start = 1'b0;
            n_checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL err_pulse num=%0d: err=%b busy=%b want 1/0",
                         bad[k], err, busy);
            end
            step();
            n_checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL err_clear num=%0d: err=%b busy=%b want 0/0",
                         bad[k], err, busy);
            end
        end
        cfg_num_seg = 4'd1;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL start_stop_idle: busy=%b err=%b want 0/0", busy, err);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        a0 = sig_amp;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1 || sig_amp !== a0 + 16'd64) begin
            n_errors++;
            $display("FAIL start_busy: err=%b busy=%b amp=%0d want 0/1/%0d",
                     err, busy, sig_amp, a0 + 16'd64);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!busy) break;
        end
        n_checks++;
        if (busy !== 1'b0 || sig_amp !== '0) begin
            n_errors++;
            $display("FAIL busy_stop_end: busy=%b amp=%0d want 0/0", busy, sig_amp);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        wr_entry(0, 1, 4000, 33, 5);
        cfg_num_seg = 4'd1;
        start = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            start = 1'b0;
            if (sig_amp >= 16'd2000) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL rstmid_ramp: amp=%0d want >=2000", sig_amp);
        end
        areset = 1'b1;
        step();
        areset = 1'b0;
        n_checks++;
        if (sig_amp !== '0 || sig_type !== '0 || sig_phase_inc !== '0 ||
            busy !== 1'b0 || seg_idx !== '0 || sig_phase_rst !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_out: amp=%0d type=%0d inc=%0d busy=%b want all 0",
                     sig_amp, sig_type, sig_phase_inc, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_checks++;
        if (sig_type !== 4'd1 || sig_phase_inc !== 16'd33 ||
            sig_phase_rst !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_table: type=%0d inc=%0d rst=%b want 1/33/1",
                     sig_type, sig_phase_inc, sig_phase_rst);
        end
        do_reset();
    endtask

    task automatic test_len0();
        wr_entry(0, 1, 128, 5, 0);
        cfg_num_seg = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        period_tick = 1'b1;
        step();
        period_tick = 1'b0;
        n_checks++;
        if (sig_amp !== 16'd64) begin
            n_errors++;
            $display("FAIL len0_slew: amp=%0d want 64", sig_amp);
        end
        step();
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (sig_amp !== 16'd128 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL len0_hold: amp=%0d busy=%b want 128/1", sig_amp, busy);
        end
        period_tick = 1'b1;
        step();
        period_tick = 1'b0;
        step();
        n_checks++;
        if (sig_amp !== 16'd64) begin
            n_errors++;
            $display("FAIL len0_down: amp=%0d want 64", sig_amp);
        end
        step();
        n_checks++;
        if (sig_amp !== '0 || done !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL len0_zero: amp=%0d done=%b busy=%b want 0/0/1",
                     sig_amp, done, busy);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sig_type !== '0) begin
            n_errors++;
            $display("FAIL len0_done: done=%b busy=%b type=%0d want 1/0/0",
                     done, busy, sig_type);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        areset = 1'b1;
        cfg_wr_en = 1'b0;
        cfg_wr_addr = '0;
        cfg_wr_type = '0;
        cfg_wr_amp = '0;
        cfg_wr_inc = '0;
        cfg_wr_len = '0;
        cfg_num_seg = '0;
        loop_en = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        period_tick = 1'b0;
        test_reset();
        test_single();
        test_loop();
        test_stop();
        test_errors();
        test_reset_mid();
        test_len0();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
